// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes, FSM states,
// ALU op/control codes, datapath select values and the packed control word.
package multicycle_control_pkg;

    localparam int STATE_W   = 4;
    localparam int ALUCTRL_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR  = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMRD   = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWR   = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECUTE = 4'd6;
    localparam logic [STATE_W-1:0] S_ALUWB   = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH  = 4'd8;
    localparam logic [STATE_W-1:0] S_ADDIEX  = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDIWB  = 4'd10;
    localparam logic [STATE_W-1:0] S_JUMP    = 4'd11;

    // ALUOp zero means add, so states that leave the ALU idle still present a defined add code.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTRL_W-1:0] ALUC_AND = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALUC_OR  = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALUC_ADD = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALUC_SUB = 3'b110;
    localparam logic [ALUCTRL_W-1:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write_uncond;
        logic       branch;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: instruction fields and zero flag in, strobes and selects out.
// master = controller side, slave = datapath side.
interface multicycle_control_if;

    logic [5:0]                                     opcode;
    logic [5:0]                                     funct;
    logic                                           zero;
    logic                                           MemWrite;
    logic                                           IorD;
    logic                                           IRWrite;
    logic                                           PCWrite;
    logic [1:0]                                     PCSrc;
    logic                                           RegWrite;
    logic                                           RegDst;
    logic                                           MemtoReg;
    logic                                           ALUSrcA;
    logic [1:0]                                     ALUSrcB;
    logic [multicycle_control_pkg::ALUCTRL_W-1:0]   ALUControl;
    logic                                           illegal_op;
    logic [multicycle_control_pkg::STATE_W-1:0]     state;

    modport master (
        input  opcode, funct, zero,
        output MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUControl, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero,
        input  MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUControl, illegal_op, state
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: ALUOp + funct -> ALUControl, flagging unsupported R-type funct codes.
// Purely combinational, zero latency; no backpressure.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0]           alu_op,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal_funct
);

    always_comb begin
        alu_control   = ALUC_ADD;
        illegal_funct = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUC_ADD;
                    FN_SUB:  alu_control = ALUC_SUB;
                    FN_AND:  alu_control = ALUC_AND;
                    FN_OR:   alu_control = ALUC_OR;
                    FN_SLT:  alu_control = ALUC_SLT;
                    // Unknown funct still computes an add so the datapath stays defined.
                    default: begin
                        alu_control   = ALUC_ADD;
                        illegal_funct = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: Moore FSM driving memory strobes and all datapath enables/selects.
// Latency 3 (beq/j), 4 (R/sw/addi) or 5 (lw) cycles per instruction; no backpressure, steps every clk.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master ctl
);

    logic [STATE_W-1:0]   state_q;
    logic [STATE_W-1:0]   state_d;
    logic [STATE_W-1:0]   dec_state;
    ctrl_t                ctrl;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 illegal_funct;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (ctl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Under reset the selects show their FETCH values; the strobes are masked separately below.
    assign dec_state = reset ? S_FETCH : state_q;

    always_comb begin
        ctrl = '0;
        case (dec_state)
            S_FETCH: begin
                ctrl.ir_write        = 1'b1;
                ctrl.pc_write_uncond = 1'b1;
                ctrl.alu_src_b       = SRCB_FOUR;
                ctrl.pc_src          = PCSRC_ALURES;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src          = PCSRC_JUMP;
                ctrl.pc_write_uncond = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    multicycle_control_alu_decoder u_alu_dec (
        .alu_op        (ctrl.alu_op),
        .funct         (ctl.funct),
        .alu_control   (alu_control),
        .illegal_funct (illegal_funct)
    );

    // Memory writes combinationally, so every strobe is gated by reset to abort in-flight work cleanly.
    assign ctl.MemWrite   = ctrl.mem_write & ~reset;
    assign ctl.IRWrite    = ctrl.ir_write  & ~reset;
    assign ctl.RegWrite   = ctrl.reg_write & ~reset;
    assign ctl.PCWrite    = (ctrl.pc_write_uncond | (ctrl.branch & ctl.zero)) & ~reset;
    assign ctl.IorD       = ctrl.iord;
    assign ctl.PCSrc      = ctrl.pc_src;
    assign ctl.RegDst     = ctrl.reg_dst;
    assign ctl.MemtoReg   = ctrl.mem_to_reg;
    assign ctl.ALUSrcA    = ctrl.alu_src_a;
    assign ctl.ALUSrcB    = ctrl.alu_src_b;
    assign ctl.ALUControl = alu_control;
    assign ctl.illegal_op = ~reset &
                            (((dec_state == S_DECODE) & ~op_supported(ctl.opcode)) |
                             ((dec_state == S_EXECUTE) & illegal_funct));
    assign ctl.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus queues per-cycle expected outputs, a monitor checks them.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    logic done = 1'b0;

    multicycle_control_if bus();

    multicycle_control u_dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mw;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic       ill;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    // Hand-written expected output table per state.
    function automatic obs_t fsm_vec(input logic [3:0] st, input logic [2:0] aluc,
                                     input logic z, input logic ill);
        obs_t v;
        v      = '0;
        v.st   = st;
        v.aluc = 3'b010;
        v.ill  = ill;
        case (st)
            4'd0:  begin v.irw = 1'b1; v.pcw = 1'b1; v.srcb = 2'b01; end
            4'd1:  v.srcb = 2'b11;
            4'd2:  begin v.srca = 1'b1; v.srcb = 2'b10; end
            4'd3:  v.iord = 1'b1;
            4'd4:  begin v.m2r = 1'b1; v.rw = 1'b1; end
            4'd5:  begin v.iord = 1'b1; v.mw = 1'b1; end
            4'd6:  begin v.srca = 1'b1; v.aluc = aluc; end
            4'd7:  begin v.rdst = 1'b1; v.rw = 1'b1; end
            4'd8:  begin v.srca = 1'b1; v.aluc = 3'b110; v.pcsrc = 2'b01; v.pcw = z; end
            4'd9:  begin v.srca = 1'b1; v.srcb = 2'b10; end
            4'd10: v.rw = 1'b1;
            4'd11: begin v.pcsrc = 2'b10; v.pcw = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    // While reset is high: FETCH selects, every strobe low, state shows the register value.
    function automatic obs_t rst_vec(input logic [3:0] st);
        obs_t v;
        v      = '0;
        v.st   = st;
        v.srcb = 2'b01;
        v.aluc = 3'b010;
        return v;
    endfunction

    task automatic push(input string n, input obs_t v);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq holds up to five state numbers, first state in the top nibble.
    task automatic run_instr(input string n, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic [19:0] seq, input int len,
                             input logic [2:0] aluc, input logic ill_dec, input logic ill_exe);
        logic [3:0] st;
        logic       ill;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        for (int i = 0; i < len; i++) begin
            st  = seq[4*(4-i) +: 4];
            ill = (st == 4'd1) ? ill_dec : ((st == 4'd6) ? ill_exe : 1'b0);
            push($sformatf("%s_c%0d", n, i), fsm_vec(st, aluc, z, ill));
        end
        repeat (len) tick();
    endtask

    task automatic sw_with_reset();
        bus.opcode = 6'h2B;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        push("swrst_c0", fsm_vec(4'd0, 3'b010, 1'b0, 1'b0));
        push("swrst_c1", fsm_vec(4'd1, 3'b010, 1'b0, 1'b0));
        push("swrst_c2", fsm_vec(4'd2, 3'b010, 1'b0, 1'b0));
        repeat (3) tick();
        reset = 1'b1;
        push("swrst_memwr_in_reset", rst_vec(4'd5));
        tick();
        reset = 1'b0;
    endtask

    initial begin : stimulus
        reset      = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        tick();
        push("reset", rst_vec(4'd0));
        tick();
        reset = 1'b0;

        run_instr("lw",        6'h23, 6'h00, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4},  5, 3'b010, 1'b0, 1'b0);
        run_instr("sw",        6'h2B, 6'h00, 1'b0, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0},  4, 3'b010, 1'b0, 1'b0);
        run_instr("beq_taken", 6'h04, 6'h00, 1'b1, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},  3, 3'b010, 1'b0, 1'b0);
        run_instr("beq_not",   6'h04, 6'h00, 1'b0, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},  3, 3'b010, 1'b0, 1'b0);
        run_instr("r_slt",     6'h00, 6'h2A, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},  4, 3'b111, 1'b0, 1'b0);
        run_instr("r_add",     6'h00, 6'h20, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},  4, 3'b010, 1'b0, 1'b0);
        run_instr("r_sub",     6'h00, 6'h22, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},  4, 3'b110, 1'b0, 1'b0);
        run_instr("r_and",     6'h00, 6'h24, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},  4, 3'b000, 1'b0, 1'b0);
        run_instr("r_or",      6'h00, 6'h25, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},  4, 3'b001, 1'b0, 1'b0);
        run_instr("r_badfn",   6'h00, 6'h3F, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0},  4, 3'b010, 1'b0, 1'b1);
        run_instr("addi",      6'h08, 6'h00, 1'b0, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0}, 4, 3'b010, 1'b0, 1'b0);
        run_instr("j",         6'h02, 6'h00, 1'b0, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0}, 3, 3'b010, 1'b0, 1'b0);
        run_instr("bad_op",    6'h3F, 6'h00, 1'b0, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0},  2, 3'b010, 1'b1, 1'b0);
        sw_with_reset();
        run_instr("lw_after",  6'h23, 6'h00, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4},  5, 3'b010, 1'b0, 1'b0);
        run_instr("end_fetch", 6'h00, 6'h20, 1'b0, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0},  1, 3'b010, 1'b0, 1'b0);
        done = 1'b1;
    end

    initial begin : monitor
        obs_t  e;
        obs_t  g;
        string n;
        forever begin
            @(negedge clk);
            if (done) break;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                g = {bus.state, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSrc,
                     bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
                     bus.ALUControl, bus.illegal_op};
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL %s: got state=%0d vec=%b, expected state=%0d vec=%b",
                             n, g.st, g, e.st, e);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
